// File: rtl/ball_motion_ctrl.sv
// Ball motion controller: holds the ball centred until start, counts down a
// serve, then moves it once per frame, bouncing off walls and paddles and
// flagging a point whenever a paddle misses.
module ball_motion_ctrl #(
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int BALL_SIZE    = 8,
  parameter int SPEED        = 2,
  parameter int SERVE_FRAMES = 60,
  parameter int X_POS_W      = 10,
  parameter int Y_POS_W      = 10
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               frame_tick_i,
  input  logic               start_i,
  input  logic               hit_left_i,
  input  logic               hit_right_i,
  output logic [X_POS_W-1:0] ball_x_o,
  output logic [Y_POS_W-1:0] ball_y_o,
  output logic [X_POS_W-1:0] ball_right_o,
  output logic [Y_POS_W-1:0] ball_bottom_o,
  output logic               score_left_o,
  output logic               score_right_o,
  output logic [1:0]         state_o
);

  localparam int CNT_W = $clog2(SERVE_FRAMES) + 1;

  localparam logic [X_POS_W-1:0] XC     = X_POS_W'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [Y_POS_W-1:0] YC     = Y_POS_W'((SCREEN_H - BALL_SIZE) / 2);
  localparam logic [X_POS_W-1:0] XSTEP  = X_POS_W'(SPEED);
  localparam logic [Y_POS_W-1:0] YSTEP  = Y_POS_W'(SPEED);
  localparam logic [X_POS_W-1:0] XREACH = X_POS_W'(BALL_SIZE + SPEED);
  localparam logic [Y_POS_W-1:0] YREACH = Y_POS_W'(BALL_SIZE + SPEED);
  localparam logic [X_POS_W-1:0] XEDGE  = X_POS_W'(SCREEN_W - 1);
  localparam logic [Y_POS_W-1:0] YEDGE  = Y_POS_W'(SCREEN_H - 1);
  localparam logic [Y_POS_W-1:0] YFLOOR = Y_POS_W'(SCREEN_H - 1 - BALL_SIZE);
  localparam logic [X_POS_W-1:0] XSPAN  = X_POS_W'(BALL_SIZE + 1);
  localparam logic [Y_POS_W-1:0] YSPAN  = Y_POS_W'(BALL_SIZE + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(SERVE_FRAMES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    PLAY  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [X_POS_W-1:0] x_q, x_d;
  logic [Y_POS_W-1:0] y_q, y_d;
  logic               dir_right_q, dir_right_d;
  logic               dir_down_q, dir_down_d;
  logic [CNT_W-1:0]   serve_cnt_q, serve_cnt_d;
  logic               hit_l_q, hit_l_d;
  logic               hit_r_q, hit_r_d;
  logic               score_left_q, score_left_d;
  logic               score_right_q, score_right_d;
  logic               miss;

  // Register all ball state; reset puts the ball centred and heading right/down.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      x_q           <= XC;
      y_q           <= YC;
      dir_right_q   <= 1'b1;
      dir_down_q    <= 1'b1;
      serve_cnt_q   <= '0;
      hit_l_q       <= 1'b0;
      hit_r_q       <= 1'b0;
      score_left_q  <= 1'b0;
      score_right_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      dir_right_q   <= dir_right_d;
      dir_down_q    <= dir_down_d;
      serve_cnt_q   <= serve_cnt_d;
      hit_l_q       <= hit_l_d;
      hit_r_q       <= hit_r_d;
      score_left_q  <= score_left_d;
      score_right_q <= score_right_d;
    end
  end

  // Next-state: hit latches persist until a frame tick consumes them (a hit on the
  // tick itself survives into the next frame), and each tick advances the game.
  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    dir_right_d   = dir_right_q;
    dir_down_d    = dir_down_q;
    serve_cnt_d   = serve_cnt_q;
    hit_l_d       = hit_left_i | (hit_l_q & ~frame_tick_i);
    hit_r_d       = hit_right_i | (hit_r_q & ~frame_tick_i);
    score_left_d  = 1'b0;
    score_right_d = 1'b0;
    miss          = 1'b0;

    case (state_q)
      IDLE: begin
        x_d = XC;
        y_d = YC;
        if (start_i) begin
          state_d     = SERVE;
          serve_cnt_d = '0;
        end
      end

      SERVE: begin
        x_d = XC;
        y_d = YC;
        if (frame_tick_i) begin
          serve_cnt_d = serve_cnt_q + 1'b1;
          if (serve_cnt_q == CNT_LAST) begin
            state_d = PLAY;
          end
        end
      end

      PLAY: begin
        if (frame_tick_i) begin
          if (!dir_right_q && hit_l_q) begin
            dir_right_d = 1'b1;
            x_d         = x_q + XSTEP;
          end else if (dir_right_q && hit_r_q) begin
            dir_right_d = 1'b0;
            x_d         = x_q - XSTEP;
          end else if (!dir_right_q && (x_q <= XSTEP)) begin
            miss          = 1'b1;
            score_right_d = 1'b1;
            dir_right_d   = 1'b0;
          end else if (dir_right_q && (x_q + XREACH >= XEDGE)) begin
            miss         = 1'b1;
            score_left_d = 1'b1;
            dir_right_d  = 1'b1;
          end else if (dir_right_q) begin
            x_d = x_q + XSTEP;
          end else begin
            x_d = x_q - XSTEP;
          end

          if (miss) begin
            x_d         = XC;
            y_d         = YC;
            serve_cnt_d = '0;
            state_d     = SERVE;
          end else if (dir_down_q && (y_q + YREACH >= YEDGE)) begin
            y_d        = YFLOOR;
            dir_down_d = 1'b0;
          end else if (!dir_down_q && (y_q <= YSTEP)) begin
            y_d        = '0;
            dir_down_d = 1'b1;
          end else if (dir_down_q) begin
            y_d = y_q + YSTEP;
          end else begin
            y_d = y_q - YSTEP;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign ball_x_o      = x_q;
  assign ball_y_o      = y_q;
  assign ball_right_o  = x_q + XSPAN;
  assign ball_bottom_o = y_q + YSPAN;
  assign score_left_o  = score_left_q;
  assign score_right_o = score_right_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Self-checking bench for ball_motion_ctrl: a behavioural game model predicts each
// frame's result into a scoreboard queue, which is popped and compared after the edge.
module tb_ball_motion_ctrl;

  localparam int XC = 316;
  localparam int YC = 236;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       start = 1'b0;
  logic       hit_left = 1'b0;
  logic       hit_right = 1'b0;
  logic [9:0] ball_x, ball_y, ball_right, ball_bottom;
  logic       score_left, score_right;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int x;
    int y;
    int st;
    int sl;
    int sr;
  } exp_t;

  exp_t sb[$];

  // Reference model state
  int m_x, m_y, m_st, m_cnt;
  bit m_right, m_down, m_hl, m_hr;

  ball_motion_ctrl dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .frame_tick_i  (frame_tick),
    .start_i       (start),
    .hit_left_i    (hit_left),
    .hit_right_i   (hit_right),
    .ball_x_o      (ball_x),
    .ball_y_o      (ball_y),
    .ball_right_o  (ball_right),
    .ball_bottom_o (ball_bottom),
    .score_left_o  (score_left),
    .score_right_o (score_right),
    .state_o       (state)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL timeout: simulation did not finish, observed running, required done");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_x = XC; m_y = YC; m_st = 0; m_cnt = 0;
    m_right = 1'b1; m_down = 1'b1; m_hl = 1'b0; m_hr = 1'b0;
  endtask

  // Advance the model by one frame tick and push the expected result.
  task automatic modelTick(input bit hl, input bit hr);
    exp_t e;
    bit   missed;
    e.sl = 0; e.sr = 0;
    missed = 1'b0;
    if (m_st == 0) begin
      if (start) begin m_st = 1; m_cnt = 0; end
    end else if (m_st == 1) begin
      if (m_cnt == 59) m_st = 2;
      m_cnt++;
    end else begin
      if (!m_right && m_hl) begin
        m_right = 1'b1; m_x += 2;
      end else if (m_right && m_hr) begin
        m_right = 1'b0; m_x -= 2;
      end else if (!m_right && m_x <= 2) begin
        missed = 1'b1; e.sr = 1;
      end else if (m_right && m_x + 10 >= 639) begin
        missed = 1'b1; e.sl = 1;
      end else begin
        m_x = m_right ? m_x + 2 : m_x - 2;
      end
      if (missed) begin
        m_x = XC; m_y = YC; m_cnt = 0; m_st = 1;
      end else if (m_down && m_y + 10 >= 479) begin
        m_y = 471; m_down = 1'b0;
      end else if (!m_down && m_y <= 2) begin
        m_y = 0; m_down = 1'b1;
      end else begin
        m_y = m_down ? m_y + 2 : m_y - 2;
      end
    end
    m_hl = hl;
    m_hr = hr;
    e.x = m_x; e.y = m_y; e.st = m_st;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL %s_queue: observed empty required entry", tag);
      return;
    end
    e = sb.pop_front();
    checkVal({tag, "_x"}, 32'(ball_x), e.x);
    checkVal({tag, "_y"}, 32'(ball_y), e.y);
    checkVal({tag, "_right"}, 32'(ball_right), e.x + 9);
    checkVal({tag, "_bottom"}, 32'(ball_bottom), e.y + 9);
    checkVal({tag, "_state"}, 32'(state), e.st);
    checkVal({tag, "_score_l"}, 32'(score_left), e.sl);
    checkVal({tag, "_score_r"}, 32'(score_right), e.sr);
  endtask

  // Drive one frame tick (optionally with coincident hits), check the result,
  // then check that any score pulse has already dropped one cycle later.
  task automatic applyStimulus(input string tag, input bit hl, input bit hr);
    @(negedge clk);
    frame_tick = 1'b1; hit_left = hl; hit_right = hr;
    modelTick(hl, hr);
    @(posedge clk); #1;
    frame_tick = 1'b0; hit_left = 1'b0; hit_right = 1'b0;
    checkOutput(tag);
    @(posedge clk); #1;
    checkVal({tag, "_pulse_end_l"}, 32'(score_left), 0);
    checkVal({tag, "_pulse_end_r"}, 32'(score_right), 0);
  endtask

  task automatic pulseHit(input bit hl, input bit hr);
    @(negedge clk);
    hit_left = hl; hit_right = hr;
    m_hl |= hl;
    m_hr |= hr;
    @(posedge clk); #1;
    hit_left = 1'b0; hit_right = 1'b0;
  endtask

  task automatic serveOut(input string tag);
    for (int i = 0; i < 60; i++) applyStimulus(tag, 1'b0, 1'b0);
  endtask

  initial begin
    bit done;
    modelReset();
    #23;
    checkVal("reset_x", 32'(ball_x), 316);
    checkVal("reset_y", 32'(ball_y), 236);
    checkVal("reset_right", 32'(ball_right), 325);
    checkVal("reset_bottom", 32'(ball_bottom), 245);
    checkVal("reset_state", 32'(state), 0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] idle ticks");
    for (int i = 0; i < 5; i++) applyStimulus("idle", 1'b0, 1'b0);

    $display("[TB] start and serve");
    @(negedge clk);
    start = 1'b1;
    modelTick(1'b0, 1'b0);
    m_cnt = 0;
    sb.pop_back();
    @(posedge clk); #1;
    checkVal("start_state", 32'(state), 1);
    serveOut("serve");
    start = 1'b0;
    checkVal("serve_done_state", 32'(state), 2);
    checkVal("serve_done_x", 32'(ball_x), 316);

    applyStimulus("first_move", 1'b0, 1'b0);
    checkVal("first_move_x", 32'(ball_x), 318);
    checkVal("first_move_y", 32'(ball_y), 238);

    $display("[TB] paddle bounces");
    pulseHit(1'b0, 1'b1);
    applyStimulus("bounce_r", 1'b0, 1'b0);
    pulseHit(1'b0, 1'b1);
    applyStimulus("ignore_r", 1'b0, 1'b0);
    done = 1'b0;
    for (int i = 0; i < 500 && !done; i++) begin
      applyStimulus("run_left", 1'b0, 1'b0);
      if (m_x <= 100) done = 1'b1;
    end
    checkVal("reached_100", 32'(done), 1);
    pulseHit(1'b1, 1'b0);
    applyStimulus("bounce_l", 1'b0, 1'b0);
    applyStimulus("after_bounce_l", 1'b0, 1'b0);
    pulseHit(1'b0, 1'b1);
    applyStimulus("bounce_r2", 1'b0, 1'b0);
    applyStimulus("coinc_l", 1'b1, 1'b0);
    applyStimulus("coinc_l_next", 1'b0, 1'b0);
    pulseHit(1'b0, 1'b1);
    applyStimulus("bounce_r3", 1'b0, 1'b0);

    $display("[TB] left miss");
    done = 1'b0;
    for (int i = 0; i < 1000 && !done; i++) begin
      applyStimulus("to_left_miss", 1'b0, 1'b0);
      if (m_st == 1) done = 1'b1;
    end
    checkVal("left_miss_seen", 32'(done), 1);
    serveOut("serve2");
    applyStimulus("after_serve2", 1'b0, 1'b0);
    pulseHit(1'b1, 1'b0);
    applyStimulus("bounce_l2", 1'b0, 1'b0);

    $display("[TB] right miss");
    done = 1'b0;
    for (int i = 0; i < 1000 && !done; i++) begin
      applyStimulus("to_right_miss", 1'b0, 1'b0);
      if (m_st == 1) done = 1'b1;
    end
    checkVal("right_miss_seen", 32'(done), 1);
    serveOut("serve3");
    for (int i = 0; i < 4; i++) applyStimulus("play3", 1'b0, 1'b0);

    $display("[TB] async reset mid-play");
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    modelReset();
    checkVal("arst_x", 32'(ball_x), 316);
    checkVal("arst_y", 32'(ball_y), 236);
    checkVal("arst_right", 32'(ball_right), 325);
    checkVal("arst_bottom", 32'(ball_bottom), 245);
    checkVal("arst_state", 32'(state), 0);
    checkVal("arst_score_l", 32'(score_left), 0);
    checkVal("arst_score_r", 32'(score_right), 0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus("post_reset_idle", 1'b0, 1'b0);

    checkVal("queue_drained", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
